sine_analyzer: RTL
==================

# sine_analyzer

Receive-side counterpart of the sine generator: consumes a strobed stream of 8-bit unsigned samples and measures the waveform. It detects rising midscale crossings with hysteresis, measures the period in samples, and captures min/max/peak-to-peak amplitude per period. It sits behind the ADC capture path, or in loopback directly on the generator's output for self-test.

## Interface
- MIDSCALE, 8'h80, crossing reference level.
- HYST, 8, hysteresis half-width in LSBs; legal range 1..127.
- PERIOD_W, 16, period counter width.
- MIN_PERIOD, 4, minimum accepted period in samples; shorter edges are rejected as glitches.
- clk  in  1  clock.
- reset  in  1  synchronous, active-high; priority over everything.
- clk_en  in  1  sample strobe; `sample_in` is consumed only on clock edges where this is 1.
- sample_in  in  8  unsigned sample.
- period_out  out  PERIOD_W  samples between the last two accepted rising crossings.
- min_out  out  8  minimum sample in the last measured period.
- max_out  out  8  maximum sample in the last measured period.
- amp_out  out  8  max_out - min_out.
- meas_valid  out  1  one-clock pulse when a new measurement is latched.
- locked  out  1  two consecutive periods agree within ±1.
- timeout  out  1  sticky no-signal flag.

## Operation
- Thresholds are computed at 9 bits and clamped to 0..255:
  - hi_th = min(MIDSCALE+HYST, 255)
  - lo_th = max(MIDSCALE-HYST, 0)
- FSM states: ACQ_LOW, ARMED, MEAS. All transitions happen only on clk_en edges.
- ACQ_LOW (reset state):
  - Counter is 0 on entry and increments on each sample.
  - When sample <= lo_th, go to ARMED.
- ARMED:
  - When sample >= hi_th (a rising event), set cnt=1 and min_run=max_run=sample, then go to MEAS.
  - No output is produced on this first edge.
- MEAS, hysteresis level bit h:
  - h is set to 1 on a rising event.
  - h is cleared when sample <= lo_th.
  - h holds otherwise.
  - A rising event requires h=0 and sample >= hi_th.
- MEAS, non-edge sample:
  - cnt increments and saturates at all-ones.
  - min_run/max_run update with the sample.
- MEAS, rising event with cnt >= MIN_PERIOD (accepted edge):
  - Latch period_out=cnt, min_out=min_run, max_out=max_run, amp_out=max_run-min_run.
  - Pulse meas_valid, clear timeout.
  - Reset cnt=1 and min_run=max_run=sample; the edge sample opens the new window.
- MEAS, rising event with cnt < MIN_PERIOD:
  - The edge is rejected: h still goes to 1, the sample is folded into min/max as an ordinary sample, and cnt increments.
- locked:
  - Set on an accepted edge where |cnt - previous period_out| <= 1 and a previous measurement exists since the last ACQ_LOW entry.
  - Cleared on an accepted edge that differs by more than 1.
  - Cleared on timeout.
- Timeout: when cnt reaches all-ones in any state:
  - timeout=1 (sticky until the next meas_valid or reset), locked=0.
  - FSM goes to ACQ_LOW and cnt=0.
  - period_out, min_out and max_out hold their values.
- Period arithmetic is unsigned PERIOD_W bits. The ±1 compare is computed at PERIOD_W+1 bits so there is no wrap.

## Timing
- All outputs are registered.
- meas_valid is high for exactly one clk cycle after the clk_en edge carrying the accepted edge sample, independent of the next clk_en.
- The data outputs update on the same edge as meas_valid and hold until the next accepted edge.
- Latency from edge sample to outputs: 1 clk.
- Reset values:
  - period_out=0, min_out=0, max_out=0, amp_out=0, meas_valid=0, locked=0, timeout=0.
  - Internal: cnt=0, h=0, min_run=8'hFF, max_run=8'h00.
  - State: ACQ_LOW.
- Reset mid-period discards the partial window. Reacquisition requires a fresh low (<= lo_th) before arming.
- reset and clk_en in the same cycle: reset wins and the sample is dropped.
- clk_en=0: no state, counter or output change except the meas_valid fall.
- The first meas_valid after reset occurs on the second accepted rising crossing.

## Test plan
- **Full-scale sine, clk_en every cycle.** Stimulus: reset, then a 2048-sample full-scale sine table (0x00..0xFF, starts at 0x80) looped. Response:
  - First meas_valid after the second rising crossing, with period_out=2048, min_out=0x00, max_out=0xFF, amp_out=0xFF.
  - locked=1 after the next measurement.
  - meas_valid pulses are 2048 clocks apart.
- **Slow strobe.** Same stimulus with clk_en every 4th clk. Response: period_out=2048, pulses 8192 clocks apart, each meas_valid exactly 1 clk wide.
- **Noise, then square wave.** Stimulus: samples alternating 0x80±7 for 100 samples, then a square wave of 5×0x70 / 5×0x90. Response:
  - No meas_valid during the noise.
  - Then period_out=10, min_out=0x70, max_out=0x90, amp_out=0x20.
- **Glitch rejection.** Stimulus: square wave of period 20, with one extra 0x70,0x90 pair injected 1 sample after an edge (MIN_PERIOD=4). Response: no extra meas_valid, and period_out stays 20.
- **Timeout.** Stimulus: PERIOD_W=8, locked on period 20, then constant 0x80. Response:
  - timeout=1 and locked=0 after the count saturates at 255.
  - period_out holds 20.
  - Restarting the square wave gives a new meas_valid after two accepted crossings, and timeout clears.
- **Reset mid-period.** Stimulus: assert reset for 1 clk mid-period. Response:
  - All outputs are 0 on the next cycle.
  - A high-starting waveform gives no measurement until it has gone <= lo_th and then made two rising crossings.

Source files
------------

// File: rtl/sine_analyzer.sv
// -----------------------------------------------------------------------------
// sine_analyzer
//
// Receive-side waveform analyzer for a strobed stream of 8-bit unsigned
// samples. Rising midscale crossings are detected with hysteresis; the number
// of samples between two accepted crossings is the period. The minimum and
// maximum sample seen within that window are reported with the period.
//
// Ports
//   clk         clock
//   reset       synchronous, active-high; overrides everything else
//   clk_en      sample strobe; sample_in is consumed only when high
//   sample_in   unsigned 8-bit sample
//   period_out  samples between the last two accepted rising crossings
//   min_out     minimum sample of the last measured period
//   max_out     maximum sample of the last measured period
//   amp_out     max_out - min_out
//   meas_valid  one-clock pulse when a new measurement is latched
//   locked      two consecutive periods agree within +/-1
//   timeout     sticky no-signal flag, cleared by the next measurement
// -----------------------------------------------------------------------------
module sine_analyzer #(
  parameter logic [7:0]  MIDSCALE   = 8'h80,
  parameter int unsigned HYST       = 8,
  parameter int unsigned PERIOD_W   = 16,
  parameter int unsigned MIN_PERIOD = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clk_en,
  input  logic [7:0]          sample_in,
  output logic [PERIOD_W-1:0] period_out,
  output logic [7:0]          min_out,
  output logic [7:0]          max_out,
  output logic [7:0]          amp_out,
  output logic                meas_valid,
  output logic                locked,
  output logic                timeout
);

  // Thresholds are formed at 9 bits so MIDSCALE +/- HYST can be clamped
  // instead of wrapping around the 8-bit range.
  localparam logic [8:0] HI_SUM = {1'b0, MIDSCALE} + 9'(HYST);
  localparam logic [8:0] LO_DIF = {1'b0, MIDSCALE} - 9'(HYST);
  localparam logic [7:0] HI_TH  = HI_SUM[8] ? 8'hFF : HI_SUM[7:0];
  localparam logic [7:0] LO_TH  = LO_DIF[8] ? 8'h00 : LO_DIF[7:0];

  localparam logic [PERIOD_W-1:0] CNT_MAX = '1;
  localparam logic [PERIOD_W-1:0] CNT_ONE = PERIOD_W'(1);
  localparam logic [PERIOD_W-1:0] MIN_CNT = PERIOD_W'(MIN_PERIOD);
  localparam logic [PERIOD_W:0]   EXT_ONE = (PERIOD_W + 1)'(1);

  typedef enum logic [1:0] {
    ACQ_LOW,
    ARMED,
    MEAS
  } state_t;

  state_t              state_q;
  logic [PERIOD_W-1:0] cnt_q;
  logic                h_q;
  logic [7:0]          min_run_q;
  logic [7:0]          max_run_q;
  logic [PERIOD_W-1:0] period_q;
  logic [7:0]          min_q;
  logic [7:0]          max_q;
  logic [7:0]          amp_q;
  logic                valid_q;
  logic                locked_q;
  logic                timeout_q;
  logic                have_meas_q;  // a measurement exists since ACQ_LOW

  logic                is_low;
  logic                is_high;
  logic                rise_evt;
  logic                accept;
  logic                counting;
  logic                tmo_hit;
  logic                near_prev;
  logic [PERIOD_W-1:0] cnt_inc;
  logic [PERIOD_W:0]   cnt_ext;
  logic [PERIOD_W:0]   per_ext;

  assign is_low   = (sample_in <= LO_TH);
  assign is_high  = (sample_in >= HI_TH);
  assign rise_evt = (state_q == MEAS) && !h_q && is_high;
  assign accept   = rise_evt && (cnt_q >= MIN_CNT);

  // The counter restarts at 1 on arming and on accepted edges; on every other
  // consumed sample it advances, and reaching all-ones is the no-signal case.
  assign counting = !((state_q == ARMED) && is_high) && !accept;
  assign cnt_inc  = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_ONE;
  assign tmo_hit  = counting && (cnt_inc == CNT_MAX);

  // One extra bit so period_q + 1 cannot wrap when period_q is all-ones.
  assign cnt_ext   = {1'b0, cnt_q};
  assign per_ext   = {1'b0, period_q};
  assign near_prev = (cnt_ext <= per_ext + EXT_ONE) && (per_ext <= cnt_ext + EXT_ONE);

  // NOTE: non-blocking assignments throughout, so every branch below reads
  // the pre-edge value of every register regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ACQ_LOW;
      cnt_q       <= '0;
      h_q         <= 1'b0;
      min_run_q   <= 8'hFF;
      max_run_q   <= 8'h00;
      period_q    <= '0;
      min_q       <= 8'h00;
      max_q       <= 8'h00;
      amp_q       <= 8'h00;
      valid_q     <= 1'b0;
      locked_q    <= 1'b0;
      timeout_q   <= 1'b0;
      have_meas_q <= 1'b0;
    end else begin
      // The pulse always falls after one clk, even without a new strobe.
      valid_q <= 1'b0;
      if (clk_en) begin
        if (tmo_hit) begin
          // Measurement outputs keep their last values through a timeout.
          state_q     <= ACQ_LOW;
          cnt_q       <= '0;
          h_q         <= 1'b0;
          timeout_q   <= 1'b1;
          locked_q    <= 1'b0;
          have_meas_q <= 1'b0;
        end else begin
          unique case (state_q)
            ACQ_LOW: begin
              cnt_q <= cnt_inc;
              if (is_low) state_q <= ARMED;
            end
            ARMED: begin
              if (is_high) begin
                // First crossing only opens a window; nothing is reported.
                state_q   <= MEAS;
                cnt_q     <= CNT_ONE;
                h_q       <= 1'b1;
                min_run_q <= sample_in;
                max_run_q <= sample_in;
              end else begin
                cnt_q <= cnt_inc;
              end
            end
            MEAS: begin
              if (accept) begin
                period_q    <= cnt_q;
                min_q       <= min_run_q;
                max_q       <= max_run_q;
                amp_q       <= max_run_q - min_run_q;
                valid_q     <= 1'b1;
                timeout_q   <= 1'b0;
                locked_q    <= have_meas_q && near_prev;
                have_meas_q <= 1'b1;
                // The edge sample belongs to the window it opens.
                cnt_q       <= CNT_ONE;
                h_q         <= 1'b1;
                min_run_q   <= sample_in;
                max_run_q   <= sample_in;
              end else begin
                // Ordinary samples and too-early (glitch) edges land here.
                cnt_q     <= cnt_inc;
                min_run_q <= (sample_in < min_run_q) ? sample_in : min_run_q;
                max_run_q <= (sample_in > max_run_q) ? sample_in : max_run_q;
                if (rise_evt)    h_q <= 1'b1;
                else if (is_low) h_q <= 1'b0;
              end
            end
            default: state_q <= ACQ_LOW;
          endcase
        end
      end
    end
  end

  assign period_out = period_q;
  assign min_out    = min_q;
  assign max_out    = max_q;
  assign amp_out    = amp_q;
  assign meas_valid = valid_q;
  assign locked     = locked_q;
  assign timeout    = timeout_q;

endmodule
